itlb_miss_ctrl: RTL and testbench
=================================

// Module: itlb_miss_ctrl
// PURPOSE
//  Sequences ITLB refill on a lookup miss: allocates a victim through plru_32, requests a walk from the PTW,
//  writes the returned translation into the chosen entry and updates PLRU state. Owns the per-entry valid vector.
//  Handles sfence flush at any point. Sits between the ITLB lookup stage, plru_32 and the shared PTW port.
// PARAMETERS
//  ENTRY_NUM  `TLB_ENTRY_SIZE (32)  number of ITLB entries; must match plru_32
//  VPN_W      27                    virtual page number width (Sv39)
//  PPN_W      44                    physical page number width
//  PERM_W     8                     PTE permission/attribute bits (V,R,W,X,U,G,A,D)
// PORTS
//  clk_i              in   1          clock
//  rst_i              in   1          asynchronous active-high reset
//  lookup_vld_i       in   1          ITLB lookup valid this cycle
//  lookup_hit_i       in   1          lookup hit (qualified by lookup_vld_i)
//  lookup_vpn_i       in   VPN_W      VPN of the lookup
//  flush_i            in   1          sfence.vma (all): invalidate every entry
//  miss_busy_o        out  1          refill in progress; fetch must stall
//  ptw_req_vld_o      out  1          walk request valid
//  ptw_req_rdy_i      in   1          PTW accepts request
//  ptw_req_vpn_o      out  VPN_W      VPN to walk
//  ptw_rsp_vld_i      in   1          walk response valid (single cycle, always accepted)
//  ptw_rsp_fault_i    in   1          walk ended in page fault
//  ptw_rsp_ppn_i      in   PPN_W      translated PPN
//  ptw_rsp_perm_i     in   PERM_W     PTE permission bits
//  entry_valid_o      out  ENTRY_NUM  per-entry valid; drives plru_32 entry_valid_i and ITLB match
//  plru_init_en_o     out  1          to plru_32 itlb_refull_init_en: latch victim index
//  plru_refill_vld_o  out  1          to plru_32 itlb_refill_vld: refill write happened
//  plru_victim_i      in   ENTRY_NUM  from plru_32 itlb_refill_onehot_o
//  tlb_wr_en_o        out  1          ITLB entry write strobe
//  tlb_wr_onehot_o    out  ENTRY_NUM  entry select for write
//  tlb_wr_vpn_o       out  VPN_W      tag written
//  tlb_wr_ppn_o       out  PPN_W      PPN written
//  tlb_wr_perm_o      out  PERM_W     perms written
//  fault_vld_o        out  1          one-cycle page-fault report to fetch
//  fault_vpn_o        out  VPN_W      faulting VPN
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; entry_valid_o=0; vpn/victim/ppn/perm regs=0.
//  FSM states: IDLE, ALLOC, REQ, WAIT, FILL, DRAIN. miss_busy_o = (state!=IDLE).
//  IDLE : lookup_vld_i & !lookup_hit_i & !flush_i -> capture lookup_vpn_i into vpn_q -> ALLOC. Hits: no action.
//  ALLOC: plru_init_en_o=1 for exactly this cycle (plru_32 registers victim at end of cycle) -> REQ.
//  REQ  : first cycle captures plru_victim_i into victim_q; ptw_req_vld_o=1, ptw_req_vpn_o=vpn_q held stable
//         until ptw_req_rdy_i; on vld&rdy -> WAIT.
//  WAIT : on ptw_rsp_vld_i: fault -> fault_vld_o=1, fault_vpn_o=vpn_q next cycle, -> IDLE, no entry write;
//         else capture ppn/perm -> FILL.
//  FILL : one cycle: tlb_wr_en_o=1, tlb_wr_onehot_o=victim_q, plru_refill_vld_o=1;
//         entry_valid_o |= victim_q at clock edge -> IDLE.
//  Latency (no backpressure, PTW rsp N cycles after accept): miss T -> ALLOC T+1 -> REQ T+2 -> FILL at rsp+1.
//  Flush (priority over all other events, same cycle):
//   entry_valid_o cleared to 0 at next edge in any state.
//   IDLE/ALLOC/REQ(not yet accepted, including vld&rdy same cycle counts as accepted) -> IDLE, no request.
//   REQ accepted same cycle or WAIT -> DRAIN: wait for ptw_rsp_vld_i, discard it (no write, no fault) -> IDLE.
//   WAIT with rsp same cycle -> IDLE, response discarded.  FILL -> write suppressed, no plru_refill_vld_o.
//  Miss lookup while busy: ignored (fetch is stalled by miss_busy_o).
//  ptw_rsp_vld_i outside WAIT/DRAIN: ignored.
//  Victim when all entries valid is PLRU choice; else lowest invalid entry (plru_32 internal rule).
//  Reset asserted mid-operation: immediate return to reset values; an in-flight PTW response after reset is
//  ignored because state is IDLE.
//  Assertions: victim_q is one-hot in FILL; ptw_req_vpn_o stable while vld&!rdy; tlb_wr_en_o implies !flush_i.
// STRUCTURE
//  mms_pkg: itlb_miss_state_e enum, VPN_W/PPN_W/PERM_W localparams, itlb_wr_t packed struct (vpn,ppn,perm).
//  Single module; no sub-module. plru_32 is instantiated alongside this block by the ITLB top, not inside it.
// TESTING
//  1 Reset, miss VPN 0x1234 at T, rdy=1, rsp ppn 0xABC after 3 cyc -> req at T+2, tlb_wr_onehot=bit0, valid=0x1.
//  2 Fill 32 sequential misses -> victims bit0..bit31 in order; entry_valid_o=0xFFFF_FFFF; 33rd uses PLRU victim.
//  3 Miss with ptw_req_rdy_i low 5 cycles -> ptw_req_vld_o held, vpn stable, single request issued.
//  4 Response with fault=1 -> fault_vld_o 1 cycle, fault_vpn_o=0x1234, no tlb_wr_en_o, entry_valid unchanged.
//  5 flush_i in WAIT -> DRAIN, valid=0; rsp 2 cycles later discarded; back in IDLE, next miss uses entry 0.
//  6 flush_i coincident with FILL -> no write, no plru_refill_vld_o, entry_valid_o=0, state IDLE.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared types and widths for the ITLB miss controller.
package mms_pkg;

  localparam int TLB_ENTRY_NUM = 32;
  localparam int VPN_W         = 27;
  localparam int PPN_W         = 44;
  localparam int PERM_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALLOC = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FILL  = 3'd4,
    ST_DRAIN = 3'd5
  } itlb_miss_state_e;

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic [PERM_W-1:0] perm;
  } itlb_wr_t;

endpackage

// File: rtl/itlb_miss_ctrl.sv
// ITLB refill sequencer: victim allocation via plru_32, PTW walk, entry write, sfence flush.
// state | meaning
// IDLE  | no refill; watching lookups for a miss
// ALLOC | plru_32 latching its victim
// REQ   | walk request presented to PTW
// WAIT  | request accepted, awaiting walk response
// FILL  | writing translation into victim entry
// DRAIN | flushed mid-walk; swallow the pending response
module itlb_miss_ctrl
  import mms_pkg::*;
#(
  parameter int ENTRY_NUM = TLB_ENTRY_NUM
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lookup_vld_i,
  input  logic                 lookup_hit_i,
  input  logic [VPN_W-1:0]     lookup_vpn_i,
  input  logic                 flush_i,
  output logic                 miss_busy_o,
  output logic                 ptw_req_vld_o,
  input  logic                 ptw_req_rdy_i,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_rsp_vld_i,
  input  logic                 ptw_rsp_fault_i,
  input  logic [PPN_W-1:0]     ptw_rsp_ppn_i,
  input  logic [PERM_W-1:0]    ptw_rsp_perm_i,
  output logic [ENTRY_NUM-1:0] entry_valid_o,
  output logic                 plru_init_en_o,
  output logic                 plru_refill_vld_o,
  input  logic [ENTRY_NUM-1:0] plru_victim_i,
  output logic                 tlb_wr_en_o,
  output logic [ENTRY_NUM-1:0] tlb_wr_onehot_o,
  output logic [VPN_W-1:0]     tlb_wr_vpn_o,
  output logic [PPN_W-1:0]     tlb_wr_ppn_o,
  output logic [PERM_W-1:0]    tlb_wr_perm_o,
  output logic                 fault_vld_o,
  output logic [VPN_W-1:0]     fault_vpn_o
);

  itlb_miss_state_e      state_q, state_d;
  itlb_wr_t              wr_q;
  logic [ENTRY_NUM-1:0]  victim_q;
  logic [ENTRY_NUM-1:0]  entry_valid_q;
  logic                  req_first_q;
  logic                  fault_vld_q;
  logic [VPN_W-1:0]      fault_vpn_q;

  logic                  capture_vpn;
  logic                  capture_rsp;
  logic                  fault_set;

  always_comb begin
    state_d           = state_q;
    plru_init_en_o    = 1'b0;
    ptw_req_vld_o     = 1'b0;
    tlb_wr_en_o       = 1'b0;
    plru_refill_vld_o = 1'b0;
    capture_vpn       = 1'b0;
    capture_rsp       = 1'b0;
    fault_set         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lookup_vld_i && !lookup_hit_i && !flush_i) begin
          capture_vpn = 1'b1;
          state_d     = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        plru_init_en_o = 1'b1;
        state_d        = flush_i ? ST_IDLE : ST_REQ;
      end
      ST_REQ: begin
        ptw_req_vld_o = 1'b1;
        // once the PTW has taken the request its response must be drained
        if (ptw_req_rdy_i) state_d = flush_i ? ST_DRAIN : ST_WAIT;
        else if (flush_i)  state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (ptw_rsp_vld_i) begin
          state_d = ST_IDLE;
          if (!flush_i) begin
            if (ptw_rsp_fault_i) begin
              fault_set = 1'b1;
            end else begin
              capture_rsp = 1'b1;
              state_d     = ST_FILL;
            end
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL: begin
        tlb_wr_en_o       = !flush_i;
        plru_refill_vld_o = !flush_i;
        state_d           = ST_IDLE;
      end
      ST_DRAIN: begin
        if (ptw_rsp_vld_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wr_q          <= '0;
      victim_q      <= '0;
      entry_valid_q <= '0;
      req_first_q   <= 1'b0;
      fault_vld_q   <= 1'b0;
      fault_vpn_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_first_q <= (state_q == ST_ALLOC) && (state_d == ST_REQ);
      if (capture_vpn) wr_q.vpn <= lookup_vpn_i;
      // plru_32 presents its registered victim in the first REQ cycle
      if ((state_q == ST_REQ) && req_first_q) victim_q <= plru_victim_i;
      if (capture_rsp) begin
        wr_q.ppn  <= ptw_rsp_ppn_i;
        wr_q.perm <= ptw_rsp_perm_i;
      end
      fault_vld_q <= fault_set;
      if (fault_set) fault_vpn_q <= wr_q.vpn;
      if (flush_i)          entry_valid_q <= '0;
      else if (tlb_wr_en_o) entry_valid_q <= entry_valid_q | victim_q;
    end
  end

  assign miss_busy_o     = (state_q != ST_IDLE);
  assign ptw_req_vpn_o   = wr_q.vpn;
  assign entry_valid_o   = entry_valid_q;
  assign tlb_wr_onehot_o = victim_q;
  assign tlb_wr_vpn_o    = wr_q.vpn;
  assign tlb_wr_ppn_o    = wr_q.ppn;
  assign tlb_wr_perm_o   = wr_q.perm;
  assign fault_vld_o     = fault_vld_q;
  assign fault_vpn_o     = fault_vpn_q;

  a_victim_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_FILL) |-> $onehot(victim_q));
  a_req_vpn_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (ptw_req_vld_o && !ptw_req_rdy_i) |=> $stable(ptw_req_vpn_o));
  a_wr_no_flush: assert property (@(posedge clk_i) disable iff (rst_i)
    tlb_wr_en_o |-> !flush_i);

endmodule

// File: tb/tb_itlb_miss_ctrl.sv
// Scenario bench for itlb_miss_ctrl with a plru_32 stand-in and an expected valid-vector model.
module tb_itlb_miss_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lookup_vld_i = 1'b0;
  logic        lookup_hit_i = 1'b0;
  logic [26:0] lookup_vpn_i = '0;
  logic        flush_i = 1'b0;
  logic        miss_busy_o;
  logic        ptw_req_vld_o;
  logic        ptw_req_rdy_i = 1'b0;
  logic [26:0] ptw_req_vpn_o;
  logic        ptw_rsp_vld_i = 1'b0;
  logic        ptw_rsp_fault_i = 1'b0;
  logic [43:0] ptw_rsp_ppn_i = '0;
  logic [7:0]  ptw_rsp_perm_i = '0;
  logic [31:0] entry_valid_o;
  logic        plru_init_en_o;
  logic        plru_refill_vld_o;
  logic [31:0] plru_victim_i;
  logic        tlb_wr_en_o;
  logic [31:0] tlb_wr_onehot_o;
  logic [26:0] tlb_wr_vpn_o;
  logic [43:0] tlb_wr_ppn_o;
  logic [7:0]  tlb_wr_perm_o;
  logic        fault_vld_o;
  logic [26:0] fault_vpn_o;

  logic [31:0] rand_pick = 32'h1;
  logic [31:0] exp_valid = '0;
  int checks = 0;
  int errors = 0;

  itlb_miss_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_vld_i(lookup_vld_i), .lookup_hit_i(lookup_hit_i), .lookup_vpn_i(lookup_vpn_i),
    .flush_i(flush_i), .miss_busy_o(miss_busy_o),
    .ptw_req_vld_o(ptw_req_vld_o), .ptw_req_rdy_i(ptw_req_rdy_i), .ptw_req_vpn_o(ptw_req_vpn_o),
    .ptw_rsp_vld_i(ptw_rsp_vld_i), .ptw_rsp_fault_i(ptw_rsp_fault_i),
    .ptw_rsp_ppn_i(ptw_rsp_ppn_i), .ptw_rsp_perm_i(ptw_rsp_perm_i),
    .entry_valid_o(entry_valid_o), .plru_init_en_o(plru_init_en_o),
    .plru_refill_vld_o(plru_refill_vld_o), .plru_victim_i(plru_victim_i),
    .tlb_wr_en_o(tlb_wr_en_o), .tlb_wr_onehot_o(tlb_wr_onehot_o), .tlb_wr_vpn_o(tlb_wr_vpn_o),
    .tlb_wr_ppn_o(tlb_wr_ppn_o), .tlb_wr_perm_o(tlb_wr_perm_o),
    .fault_vld_o(fault_vld_o), .fault_vpn_o(fault_vpn_o)
  );

  always #5 clk_i = ~clk_i;

  // lowest invalid entry, else the PLRU choice supplied by the scenario
  function automatic logic [31:0] pick_victim(input logic [31:0] valid, input logic [31:0] full_pick);
    for (int i = 0; i < 32; i++) if (!valid[i]) return 32'h1 << i;
    return full_pick;
  endfunction

  // plru_32 stand-in: registers its victim when init_en is seen
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) plru_victim_i <= '0;
    else if (plru_init_en_o) plru_victim_i <= pick_victim(entry_valid_o, rand_pick);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_miss(input logic [26:0] vpn, input int rdy_dly, input int rsp_dly,
                         input bit fault, input logic [43:0] ppn, input logic [7:0] perm);
    logic [31:0] vic;
    vic = pick_victim(exp_valid, rand_pick);
    lookup_vld_i = 1'b1; lookup_hit_i = 1'b0; lookup_vpn_i = vpn;
    tick();
    lookup_vld_i = 1'b0; lookup_vpn_i = 27'($urandom);
    checks++;
    if ({miss_busy_o, plru_init_en_o, ptw_req_vld_o} !== 3'b110) begin
      errors++; $display("FAIL alloc busy/init/req got %b exp 110", {miss_busy_o, plru_init_en_o, ptw_req_vld_o});
    end
    tick();
    for (int i = 0; i < rdy_dly; i++) begin
      checks++;
      if (ptw_req_vld_o !== 1'b1 || ptw_req_vpn_o !== vpn) begin
        errors++; $display("FAIL req_hold vld %b vpn %h exp vld 1 vpn %h", ptw_req_vld_o, ptw_req_vpn_o, vpn);
      end
      tick();
    end
    checks++;
    if (ptw_req_vld_o !== 1'b1 || ptw_req_vpn_o !== vpn) begin
      errors++; $display("FAIL req vld %b vpn %h exp vld 1 vpn %h", ptw_req_vld_o, ptw_req_vpn_o, vpn);
    end
    ptw_req_rdy_i = 1'b1;
    tick();
    ptw_req_rdy_i = 1'b0;
    checks++;
    if ({miss_busy_o, ptw_req_vld_o} !== 2'b10) begin
      errors++; $display("FAIL wait busy/req got %b exp 10", {miss_busy_o, ptw_req_vld_o});
    end
    repeat (rsp_dly) tick();
    ptw_rsp_vld_i = 1'b1; ptw_rsp_fault_i = fault; ptw_rsp_ppn_i = ppn; ptw_rsp_perm_i = perm;
    tick();
    ptw_rsp_vld_i = 1'b0; ptw_rsp_fault_i = 1'b0;
    ptw_rsp_ppn_i = {12'($urandom), 32'($urandom)}; ptw_rsp_perm_i = 8'($urandom);
    if (fault) begin
      checks++;
      if ({fault_vld_o, tlb_wr_en_o, miss_busy_o} !== 3'b100 || fault_vpn_o !== vpn) begin
        errors++; $display("FAIL fault flags %b vpn %h exp 100 vpn %h",
                           {fault_vld_o, tlb_wr_en_o, miss_busy_o}, fault_vpn_o, vpn);
      end
      tick();
      checks++;
      if (fault_vld_o !== 1'b0 || tlb_wr_en_o !== 1'b0 || entry_valid_o !== exp_valid) begin
        errors++; $display("FAIL fault_after fvld %b wr %b valid %h exp 0 0 %h",
                           fault_vld_o, tlb_wr_en_o, entry_valid_o, exp_valid);
      end
    end else begin
      checks++;
      if (tlb_wr_en_o !== 1'b1 || plru_refill_vld_o !== 1'b1 || tlb_wr_onehot_o !== vic) begin
        errors++; $display("FAIL fill_ctl wr %b refill %b onehot %h exp 1 1 %h",
                           tlb_wr_en_o, plru_refill_vld_o, tlb_wr_onehot_o, vic);
      end
      checks++;
      if (tlb_wr_vpn_o !== vpn || tlb_wr_ppn_o !== ppn || tlb_wr_perm_o !== perm) begin
        errors++; $display("FAIL fill_data vpn %h ppn %h perm %h exp %h %h %h",
                           tlb_wr_vpn_o, tlb_wr_ppn_o, tlb_wr_perm_o, vpn, ppn, perm);
      end
      tick();
      exp_valid = exp_valid | vic;
      checks++;
      if (entry_valid_o !== exp_valid || miss_busy_o !== 1'b0 || tlb_wr_en_o !== 1'b0) begin
        errors++; $display("FAIL fill_after valid %h busy %b wr %b exp %h 0 0",
                           entry_valid_o, miss_busy_o, tlb_wr_en_o, exp_valid);
      end
    end
  endtask

  // drive a miss up to the first WAIT cycle (request accepted immediately)
  task automatic miss_to_wait(input logic [26:0] vpn);
    lookup_vld_i = 1'b1; lookup_hit_i = 1'b0; lookup_vpn_i = vpn;
    tick();
    lookup_vld_i = 1'b0;
    tick();
    ptw_req_rdy_i = 1'b1;
    tick();
    ptw_req_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    checks++;
    if ({miss_busy_o, ptw_req_vld_o, plru_init_en_o, plru_refill_vld_o, tlb_wr_en_o, fault_vld_o} !== 6'b0 ||
        entry_valid_o !== 32'h0 || tlb_wr_onehot_o !== 32'h0 || ptw_req_vpn_o !== 27'h0 ||
        tlb_wr_ppn_o !== 44'h0 || tlb_wr_perm_o !== 8'h0 || fault_vpn_o !== 27'h0) begin
      errors++; $display("FAIL reset_state busy %b req %b valid %h onehot %h exp all zero",
                         miss_busy_o, ptw_req_vld_o, entry_valid_o, tlb_wr_onehot_o);
    end
    rst_i = 1'b0;
    tick();
    exp_valid = '0;
  endtask

  task automatic test_basic();
    do_miss(27'h1234, 0, 2, 1'b0, 44'hABC, 8'($urandom));
    checks++;
    if (entry_valid_o !== 32'h1) begin
      errors++; $display("FAIL basic_valid got %h exp 00000001", entry_valid_o);
    end
  endtask

  task automatic test_fill_all();
    for (int i = 1; i < 32; i++)
      do_miss(27'($urandom), 0, $urandom_range(0, 2), 1'b0, {12'($urandom), 32'($urandom)}, 8'($urandom));
    checks++;
    if (entry_valid_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL fill_all_valid got %h exp ffffffff", entry_valid_o);
    end
    rand_pick = 32'h1 << $urandom_range(1, 31);
    do_miss(27'($urandom), 0, 1, 1'b0, {12'($urandom), 32'($urandom)}, 8'($urandom));
  endtask

  task automatic test_backpressure();
    rand_pick = 32'h1 << $urandom_range(0, 31);
    do_miss(27'($urandom), 5, 1, 1'b0, {12'($urandom), 32'($urandom)}, 8'($urandom));
  endtask

  task automatic test_fault();
    do_miss(27'h1234, 1, 3, 1'b1, {12'($urandom), 32'($urandom)}, 8'($urandom));
  endtask

  task automatic test_hit_and_stray();
    for (int i = 0; i < 4; i++) begin
      lookup_vld_i = 1'b1; lookup_hit_i = 1'b1; lookup_vpn_i = 27'($urandom);
      tick();
      checks++;
      if (miss_busy_o !== 1'b0 || plru_init_en_o !== 1'b0) begin
        errors++; $display("FAIL hit_idle busy %b init %b exp 0 0", miss_busy_o, plru_init_en_o);
      end
    end
    lookup_vld_i = 1'b0; lookup_hit_i = 1'b0;
    ptw_rsp_vld_i = 1'b1;
    tick();
    ptw_rsp_vld_i = 1'b0;
    tick();
    checks++;
    if (miss_busy_o !== 1'b0 || tlb_wr_en_o !== 1'b0 || entry_valid_o !== exp_valid) begin
      errors++; $display("FAIL stray_rsp busy %b wr %b valid %h exp 0 0 %h",
                         miss_busy_o, tlb_wr_en_o, entry_valid_o, exp_valid);
    end
  endtask

  task automatic test_flush_wait();
    miss_to_wait(27'($urandom));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_valid = '0;
    checks++;
    if (miss_busy_o !== 1'b1 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL flush_wait busy %b valid %h exp 1 0", miss_busy_o, entry_valid_o);
    end
    tick();
    ptw_rsp_vld_i = 1'b1; ptw_rsp_fault_i = 1'b0;
    #1;
    checks++;
    if (tlb_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL drain_wr got %b exp 0", tlb_wr_en_o);
    end
    tick();
    ptw_rsp_vld_i = 1'b0;
    checks++;
    if ({miss_busy_o, tlb_wr_en_o, fault_vld_o} !== 3'b000 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL drain_done flags %b valid %h exp 000 0",
                         {miss_busy_o, tlb_wr_en_o, fault_vld_o}, entry_valid_o);
    end
    do_miss(27'($urandom), 0, 0, 1'b0, {12'($urandom), 32'($urandom)}, 8'($urandom));
    checks++;
    if (entry_valid_o !== 32'h1) begin
      errors++; $display("FAIL flush_then_entry0 got %h exp 00000001", entry_valid_o);
    end
  endtask

  task automatic test_flush_fill();
    miss_to_wait(27'($urandom));
    ptw_rsp_vld_i = 1'b1; ptw_rsp_fault_i = 1'b0;
    tick();
    ptw_rsp_vld_i = 1'b0;
    checks++;
    if (tlb_wr_en_o !== 1'b1) begin
      errors++; $display("FAIL fill_reached wr got %b exp 1", tlb_wr_en_o);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (tlb_wr_en_o !== 1'b0 || plru_refill_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_fill_suppress wr %b refill %b exp 0 0", tlb_wr_en_o, plru_refill_vld_o);
    end
    tick();
    flush_i = 1'b0;
    exp_valid = '0;
    checks++;
    if (miss_busy_o !== 1'b0 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL flush_fill_after busy %b valid %h exp 0 0", miss_busy_o, entry_valid_o);
    end
  endtask

  task automatic test_flush_req();
    lookup_vld_i = 1'b1; lookup_hit_i = 1'b0; lookup_vpn_i = 27'($urandom); flush_i = 1'b1;
    tick();
    lookup_vld_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_miss busy got %b exp 0", miss_busy_o);
    end
    lookup_vld_i = 1'b1; lookup_vpn_i = 27'($urandom);
    tick();
    lookup_vld_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b0 || ptw_req_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_alloc busy %b req %b exp 0 0", miss_busy_o, ptw_req_vld_o);
    end
    lookup_vld_i = 1'b1; lookup_vpn_i = 27'($urandom);
    tick();
    lookup_vld_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b0 || ptw_req_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_req_norq busy %b req %b exp 0 0", miss_busy_o, ptw_req_vld_o);
    end
    lookup_vld_i = 1'b1; lookup_vpn_i = 27'($urandom);
    tick();
    lookup_vld_i = 1'b0;
    tick();
    flush_i = 1'b1; ptw_req_rdy_i = 1'b1;
    tick();
    flush_i = 1'b0; ptw_req_rdy_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b1 || ptw_req_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_req_acc busy %b req %b exp 1 0", miss_busy_o, ptw_req_vld_o);
    end
    ptw_rsp_vld_i = 1'b1;
    tick();
    ptw_rsp_vld_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b0 || fault_vld_o !== 1'b0 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL flush_req_drain busy %b fault %b valid %h exp 0 0 0",
                         miss_busy_o, fault_vld_o, entry_valid_o);
    end
    exp_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_miss(27'($urandom), 0, 0, 1'b0, {12'($urandom), 32'($urandom)}, 8'($urandom));
    miss_to_wait(27'($urandom));
    rst_i = 1'b1;
    #1;
    checks++;
    if (miss_busy_o !== 1'b0 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL reset_async busy %b valid %h exp 0 0", miss_busy_o, entry_valid_o);
    end
    tick();
    rst_i = 1'b0;
    exp_valid = '0;
    ptw_rsp_vld_i = 1'b1;
    tick();
    ptw_rsp_vld_i = 1'b0;
    checks++;
    if (miss_busy_o !== 1'b0 || tlb_wr_en_o !== 1'b0 || entry_valid_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid_rsp busy %b wr %b valid %h exp 0 0 0",
                         miss_busy_o, tlb_wr_en_o, entry_valid_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      rand_pick = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) begin
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        exp_valid = '0;
        checks++;
        if (entry_valid_o !== 32'h0) begin
          errors++; $display("FAIL rand_flush valid %h exp 0", entry_valid_o);
        end
      end
      do_miss(27'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
              {12'($urandom), 32'($urandom)}, 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_all();
    test_backpressure();
    test_fault();
    test_hit_and_stray();
    test_flush_wait();
    test_flush_fill();
    test_flush_req();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
